// File: rtl/display_text_pkg.sv
// Shared character constants, state type and helpers for the display text writer.
package display_text_pkg;

  typedef byte unsigned char_t;

  localparam char_t ASCII_SPACE     = 8'h20;
  localparam char_t ASCII_BS        = 8'h08;
  localparam char_t ASCII_DEL       = 8'h7F;
  localparam char_t ASCII_CR        = 8'h0D;
  localparam char_t ASCII_ESC       = 8'h1B;
  localparam char_t ESC_CMD_CLEAR   = 8'h43;
  localparam char_t ESC_CMD_RESTORE = 8'h52;

  typedef enum logic {IDLE, ESC} writer_state_t;

  function automatic logic is_printable(input char_t c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/uart_display_writer.sv
// Terminal-style writer for the seven-segment character buffer: append with
// scroll, backspace, clear and ESC commands, echoing accepted bytes to the UART.
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data (no ready, the
// block accepts every byte); tx_start is a one-cycle strobe qualifying tx_data.
module uart_display_writer
  import display_text_pkg::*;
#(
  parameter int                       NUM_DIGITS  = 8,
  parameter logic [NUM_DIGITS*8-1:0]  INIT_TEXT   = {NUM_DIGITS{8'h20}},
  parameter int                       ESC_TIMEOUT = 1_000_000,
  parameter bit                       ECHO_EN     = 1'b1,
  localparam int                      CNT_W       = $clog2(NUM_DIGITS + 1),
  localparam int                      TMO_W       = (ESC_TIMEOUT > 1) ? $clog2(ESC_TIMEOUT) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [NUM_DIGITS*8-1:0] digits,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  output logic [CNT_W-1:0]        char_count,
  output logic                    esc_active
);

  localparam logic [NUM_DIGITS*8-1:0] BLANK     = {NUM_DIGITS{ASCII_SPACE}};
  localparam logic [CNT_W-1:0]        COUNT_MAX = CNT_W'(NUM_DIGITS);
  localparam logic [TMO_W-1:0]        TMO_LAST  = TMO_W'(ESC_TIMEOUT - 1);

  writer_state_t           state_q, state_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [NUM_DIGITS*8-1:0] digits_q, digits_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_start_q, tx_start_d;
  logic                    esc_active_q;
  logic                    echo;
  logic [7:0]              echo_byte;

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    digits_d   = digits_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    echo       = 1'b0;
    echo_byte  = 8'h00;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (is_printable(rx_data)) begin
            // digits[0] is the rightmost character, so new text enters at the LSB end
            digits_d  = {digits_q[NUM_DIGITS*8-9:0], rx_data};
            if (count_q != COUNT_MAX) count_d = count_q + CNT_W'(1);
            echo      = 1'b1;
            echo_byte = rx_data;
          end else if ((rx_data == ASCII_BS) || (rx_data == ASCII_DEL)) begin
            if (count_q != '0) begin
              digits_d  = {ASCII_SPACE, digits_q[NUM_DIGITS*8-1:8]};
              count_d   = count_q - CNT_W'(1);
              echo      = 1'b1;
              echo_byte = ASCII_BS;
            end
          end else if (rx_data == ASCII_CR) begin
            digits_d  = BLANK;
            count_d   = '0;
            echo      = 1'b1;
            echo_byte = ASCII_CR;
          end else if (rx_data == ASCII_ESC) begin
            state_d = ESC;
            tmo_d   = '0;
          end
        end
      end
      ESC: begin
        tmo_d = tmo_q + TMO_W'(1);
        // An argument byte takes priority over an expiring timeout
        if (rx_valid) begin
          state_d = IDLE;
          tmo_d   = '0;
          case (rx_data)
            ASCII_ESC: state_d = ESC;
            ESC_CMD_CLEAR: begin
              digits_d = BLANK;
              count_d  = '0;
            end
            ESC_CMD_RESTORE: begin
              digits_d = INIT_TEXT;
              count_d  = '0;
            end
            default: ;
          endcase
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          tmo_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (echo && ECHO_EN) begin
      tx_start_d = 1'b1;
      tx_data_d  = echo_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      digits_q     <= INIT_TEXT;
      count_q      <= '0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      esc_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      digits_q     <= digits_d;
      count_q      <= count_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      esc_active_q <= (state_d == ESC);
    end
  end

  assign digits     = digits_q;
  assign char_count = count_q;
  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign esc_active = esc_active_q;

endmodule
